// File: rtl/add_seq_ctrl.sv
// ---------------------------------------------------------------------------
// add_seq_ctrl
//   Multi-precision add/subtract sequencer. Two WIDTH-bit operands are latched
//   on an accepted start, then one nibble per clock is pushed through a single
//   4-bit `add` cell, least significant nibble first, with the carry chained
//   through a register. The finished result (sum, carry out, signed overflow)
//   is published together with a one-cycle done pulse.
//
//   Ports
//     clk    in   1      rising-edge clock
//     rst    in   1      asynchronous reset, active high
//     start  in   1      request, sampled only while not busy
//     sub    in   1      0: a+b+cin, 1: a-b (cin ignored)
//     a, b   in   WIDTH  operands, latched at the accepting edge
//     cin    in   1      carry in for the add case
//     busy   out  1      operation in progress
//     done   out  1      one-cycle pulse, result updated
//     sum    out  WIDTH  result, held between done pulses
//     cout   out  1      carry out of the MSB nibble (sub: 1 = no borrow)
//     ovf    out  1      two's-complement overflow of the result
//
// add
//   4-bit adder cell: {cout, sum} = a + b + cin.
// ---------------------------------------------------------------------------

module add (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);

   // Plain 5-bit addition; the top bit is the nibble carry out.
   always_comb begin
      {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
   end

endmodule

module add_seq_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NIB = WIDTH / 4;
   localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           next_state;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] res;
   logic             carry;
   logic [KW-1:0]    k;

   logic [3:0]       nib_a;
   logic [3:0]       nib_b;
   logic [3:0]       nib_s;
   logic             nib_co;

   logic             accept;
   logic             last;

   // A request is taken whenever no operation is running, which includes the
   // DONE cycle so back-to-back operations need no idle gap.
   assign accept = start && (state != RUN);
   assign last   = (k == K_LAST);
   assign busy   = (state == RUN);
   assign done   = (state == DONE);

   // Select the current nibble of each latched operand.
   assign nib_a = a_q[{k, 2'b00} +: 4];
   assign nib_b = b_eff[{k, 2'b00} +: 4];

   add u_add (
      .a    (nib_a),
      .b    (nib_b),
      .cin  (carry),
      .sum  (nib_s),
      .cout (nib_co)
   );

   // The accumulator with the current nibble slotted in; on the last step this
   // is the complete result, which lets it be published on the same edge.
   always_comb begin
      res = acc;
      res[{k, 2'b00} +: 4] = nib_s;
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: RUN lasts exactly NIB cycles, DONE exactly one.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = RUN;
            end
         end
         RUN: begin
            if (last) begin
               next_state = DONE;
            end
         end
         DONE: begin
            next_state = start ? RUN : IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Datapath. Subtraction is a + ~b + 1, so the inversion is done once at
   // acceptance and the carry register is primed with 1. The published
   // outputs only move on the final nibble, so they hold the previous result
   // throughout RUN.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q   <= '0;
         b_eff <= '0;
         acc   <= '0;
         carry <= 1'b0;
         k     <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else if (accept) begin
         a_q   <= a;
         b_eff <= sub ? ~b : b;
         carry <= sub ? 1'b1 : cin;
         acc   <= '0;
         k     <= '0;
      end else if (state == RUN) begin
         acc   <= res;
         carry <= nib_co;
         k     <= k + 1'b1;
         if (last) begin
            sum  <= res;
            cout <= nib_co;
            ovf  <= (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
         end
      end
   end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_add_seq_ctrl
//   Scoreboard bench for add_seq_ctrl (WIDTH=16). The stimulus side pushes the
//   expected result, computed with plain integer arithmetic, whenever it issues
//   a request that will be accepted; a separate monitor pops and compares on
//   every done pulse, and also checks latency, busy length and result holding.
// ---------------------------------------------------------------------------

module tb_add_seq_ctrl;

   localparam int WIDTH = 16;
   localparam int NIB   = WIDTH / 4;

   logic             clk;
   logic             rst;
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int busyCnt  = 0;

   logic [17:0] expQ[$];
   int          acceptCycQ[$];

   logic [15:0] heldSum  = '0;
   logic        heldCout = 1'b0;
   logic        heldOvf  = 1'b0;

   add_seq_ctrl #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Cycle counter used for latency measurement.
   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   // Safety net so the run can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout actual=running required=finished");
      $fatal(1, "[TB] simulation timeout");
   end

   // Reference result {sum, cout, ovf} from integer arithmetic on the operands.
   function automatic logic [17:0] model(input logic [15:0] av, input logic [15:0] bv,
                                         input logic ci, input logic su);
      logic [31:0] full;
      int          sr;
      if (su) begin
         full = {16'h0000, av} + {16'h0000, ~bv} + 32'd1;
         sr   = int'($signed(av)) - int'($signed(bv));
      end else begin
         full = {16'h0000, av} + {16'h0000, bv} + {31'd0, ci};
         sr   = int'($signed(av)) + int'($signed(bv)) + int'({31'd0, ci});
      end
      return {full[15:0], full[16], (sr > 32767) || (sr < -32768)};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Issue one request at the first negedge where the DUT is not busy, so it
   // is accepted at the following rising edge; the expectation is queued now.
   task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                                input logic ci, input logic su, input bit keep);
      int guard = 0;
      @(negedge clk);
      while (busy && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("busy_wait_bound", (guard >= 100) ? 32'd1 : 32'd0, 32'd0);
      a     = av;
      b     = bv;
      cin   = ci;
      sub   = su;
      start = 1'b1;
      expQ.push_back(model(av, bv, ci, su));
      acceptCycQ.push_back(cyc + 1);
      @(posedge clk);
      #1;
      if (!keep) begin
         start = 1'b0;
      end
   endtask

   // Wait until every queued expectation has been consumed.
   task automatic waitDrain();
      int guard = 0;
      while ((expQ.size() != 0 || busy || done) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("drain_bound", expQ.size(), 0);
   endtask

   // Monitor: compares each done pulse against the scoreboard, checks the
   // start-to-done latency, the busy length and that the result outputs stay
   // frozen while an operation runs.
   always @(negedge clk) begin
      logic [17:0] e;
      int          ac;
      if (rst) begin
         busyCnt = 0;
      end else begin
         if (busy) begin
            busyCnt++;
            checkOutput("hold_sum", sum, heldSum);
            checkOutput("hold_cout", cout, heldCout);
            checkOutput("hold_ovf", ovf, heldOvf);
         end
         if (done) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
               e  = expQ.pop_front();
               ac = acceptCycQ.pop_front();
               checkOutput("sum", sum, e[17:2]);
               checkOutput("cout", cout, e[1]);
               checkOutput("ovf", ovf, e[0]);
               checkOutput("latency", cyc - ac, NIB);
               checkOutput("busy_cycles", busyCnt, NIB);
               checkOutput("busy_at_done", busy, 0);
               heldSum  = e[17:2];
               heldCout = e[1];
               heldOvf  = e[0];
            end
            busyCnt = 0;
         end
      end
   end

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      sub   = 1'b0;
      a     = '0;
      b     = '0;
      cin   = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_sum", sum, 0);
      checkOutput("reset_cout", cout, 0);
      checkOutput("reset_ovf", ovf, 0);

      // Directed cases with known answers.
      applyStimulus(16'h1234, 16'h0FCD, 1'b0, 1'b0, 1'b0);
      applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
      applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
      applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0);
      applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
      waitDrain();
      checkOutput("dir_sub_sum", sum, 16'h7FFF);

      // Start while busy is ignored; operand changes after acceptance too.
      applyStimulus(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      a     = 16'hFFFF;
      b     = 16'hFFFF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a     = 16'h1234;
      b     = 16'h5678;
      sub   = 1'b1;
      waitDrain();
      repeat (3) @(negedge clk);
      checkOutput("ignored_start_sum", sum, 16'h0002);
      checkOutput("ignored_start_idle", busy, 0);

      // Start held high straight through the DONE cycle: back-to-back accept.
      applyStimulus(16'h0100, 16'h0200, 1'b0, 1'b0, 1'b1);
      applyStimulus(16'h0010, 16'h0020, 1'b0, 1'b0, 1'b0);
      waitDrain();
      checkOutput("b2b_sum", sum, 16'h0030);

      // Reset in the middle of an operation.
      applyStimulus(16'hABCD, 16'h1111, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_done", done, 0);
      checkOutput("abort_sum", sum, 0);
      checkOutput("abort_cout", cout, 0);
      checkOutput("abort_ovf", ovf, 0);
      expQ.delete();
      acceptCycQ.delete();
      heldSum  = '0;
      heldCout = 1'b0;
      heldOvf  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
      waitDrain();
      checkOutput("after_abort_sum", sum, 16'h0100);

      // Randomized traffic, including zero-gap back-to-back requests.
      for (int i = 0; i < 60; i++) begin
         logic [15:0] ra;
         logic [15:0] rb;
         int          gap;
         ra  = 16'($urandom);
         rb  = 16'($urandom);
         gap = $urandom_range(0, 3);
         if ((i % 8) == 0) begin
            ra = 16'h8000 | ra;
            rb = 16'h8000 | rb;
         end
         applyStimulus(ra, rb, 1'($urandom), 1'($urandom), 1'b0);
         repeat (gap) @(negedge clk);
      end
      waitDrain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
